xoodoo_sponge_ctrl: RTL and testbench
=====================================

XOODOO_SPONGE_CTRL -- requirements
Module: xoodoo_sponge_ctrl

Interface
REQ-001 SHALL provide parameter: RATE_WORDS, 4, number of 32-bit state words absorbed and squeezed per block (legal range 2..12).
REQ-002 SHALL provide ports:
- clk  in  1  sole clock; all logic on its rising edge
- resetn  in  1  reset; synchronous, active-low
- msg_data  in  32  message word
- msg_valid  in  1  message word present
- msg_last  in  1  qualifies msg_data as final message word
- msg_ready  out  1  block accepts a message word
- perm_enable  out  1  permutation start pulse, drives enable_xoodoo
- perm_state_in  out  384  state to permute, bit order [0:383]
- perm_state_out  in  384  permuted state, bit order [0:383]
- perm_done  in  1  one-cycle permutation-complete pulse
- digest_data  out  32  output word
- digest_valid  out  1  digest_data valid
- digest_ready  in  1  consumer accepts digest_data
- busy  out  1  high in every state except IDLE

Function
REQ-003 SHALL hold a 384-bit state register S; perm_state_in = S continuously. State word i = S[32i:32i+31], and msg_data[31] maps to S[32i].
REQ-004 SHALL implement FSM states IDLE, ABSORB, PERM_START, PERM_WAIT, SQUEEZE, plus a word counter cnt (0..RATE_WORDS-1), a final flag and a pad_pending flag.
REQ-005 IDLE: msg_ready=1. An accepted word (msg_valid & msg_ready) is processed exactly as in ABSORB with cnt=0.
REQ-006 ABSORB: msg_ready=1. Each accepted word is XORed into word cnt of S. cnt then increments.
REQ-007 On an accepted word with msg_last=0: when cnt+1 == RATE_WORDS, the block SHALL go to PERM_START with cnt=0; otherwise it stays in ABSORB.
REQ-008 On an accepted word with msg_last=1: final=1 and the block goes to PERM_START. If cnt+1 < RATE_WORDS, the same cycle also XORs 32'h00000001 into word cnt+1. Otherwise pad_pending=1.
REQ-009 PERM_START SHALL last exactly one cycle with perm_enable=1; perm_enable SHALL be 0 in every other state. The next state is PERM_WAIT.
REQ-010 PERM_WAIT: S SHALL stay stable until perm_done. On perm_done, S <= perm_state_out in the same edge. Transitions:
- pad_pending=1: word 0 of the captured value is XORed with 32'h00000001, pad_pending is cleared, next state PERM_START.
- final=1 and pad_pending=0: next state SQUEEZE with cnt=0.
- otherwise: next state ABSORB with cnt=0.
REQ-011 perm_done SHALL be ignored in every state except PERM_WAIT. The wait has no timeout.
REQ-012 msg_ready SHALL be 0 in PERM_START, PERM_WAIT and SQUEEZE.
REQ-013 SQUEEZE: digest_valid=1 and digest_data = word cnt of S. On digest_valid & digest_ready, cnt increments.
REQ-014 SQUEEZE, last word: the handshake that completes word RATE_WORDS-1 SHALL clear S to zero, clear cnt and final, and return to IDLE.
REQ-015 SQUEEZE, stall: while digest_ready=0, digest_data and digest_valid SHALL hold.
REQ-016 digest_valid SHALL be 0 outside SQUEEZE.
REQ-017 Latency from the accepting edge of the block's final word to perm_enable high SHALL be 1 cycle. Latency from the perm_done edge to digest_valid high SHALL be 1 cycle.

Reset
REQ-018 When resetn=0 at a rising edge, the block SHALL set:
- state IDLE
- S=0, cnt=0, final=0, pad_pending=0
- perm_enable=0, digest_valid=0, msg_ready=0 during reset, busy=0
REQ-019 Reset asserted in any state SHALL abort the operation with no output pulse.
REQ-020 A perm_done arriving after reset SHALL have no effect.

Verification
REQ-021 Reset: hold resetn=0 for 2 cycles, then release -> busy=0, msg_ready=1, perm_enable=0, digest_valid=0, S=0.
REQ-022 Single word: RATE_WORDS=4, word 0xA5A5A5A5 with msg_last=1 ->
- one-cycle perm_enable on the next cycle
- perm_state_in[0:63] = 0xA5A5A5A5_00000001, rest zero
- model returns P; digest words = P words 0..3 in order
REQ-023 Full last block: words 1,2,3,4, last on 4 -> two perm_enable pulses. Second perm_state_in = first perm_state_out with word 0 XOR 1. Exactly 4 digest words follow.
REQ-024 Backpressure: digest_ready=0 for 5 cycles on word 2 -> digest_data stable and no word skipped or repeated. Also, msg_valid=1 during PERM_WAIT -> msg_ready=0 and no word is absorbed.
REQ-025 Reset mid-permutation: resetn=0 for 1 cycle in PERM_WAIT, then a perm_done pulse -> state IDLE, S=0, no digest_valid.
REQ-026 Back-to-back messages: two 5-word messages separated by 0 idle cycles -> digests match the reference model each time, and the second message starts from S=0.

Source files
------------

// File: rtl/xoodoo_sponge_ctrl.sv
// Xoodoo sponge controller: absorbs RATE_WORDS-word blocks, pads with 0x01, runs the external permutation, squeezes one block.
// Latency: 1 cycle from final word to perm_enable and from perm_done to digest_valid; msg_ready drops while permuting, digest holds on !digest_ready.
module xoodoo_sponge_ctrl #(
  parameter int RATE_WORDS = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [31:0]  msg_data,
  input  logic         msg_valid,
  input  logic         msg_last,
  output logic         msg_ready,
  output logic         perm_enable,
  output logic [0:383] perm_state_in,
  input  logic [0:383] perm_state_out,
  input  logic         perm_done,
  output logic [31:0]  digest_data,
  output logic         digest_valid,
  input  logic         digest_ready,
  output logic         busy
);

  localparam int CW = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(RATE_WORDS - 1);

  typedef enum logic [2:0] {IDLE, ABSORB, PERM_START, PERM_WAIT, SQUEEZE} state_t;

  state_t        state;
  logic [0:383]  s;
  logic [CW-1:0] cnt;
  logic          fin;
  logic          pad_pending;

  logic [CW-1:0] widx;
  logic [CW-1:0] widx_nxt;
  logic [8:0]    wr_base;
  logic [8:0]    pad_base;
  logic [8:0]    rd_base;
  logic          accept;

  // A word accepted in IDLE always lands in word 0 of a fresh message.
  assign widx     = (state == IDLE) ? '0 : cnt;
  assign widx_nxt = widx + 1'b1;
  assign wr_base  = 9'(widx) << 5;
  assign pad_base = 9'(widx_nxt) << 5;
  assign rd_base  = 9'(cnt) << 5;

  assign msg_ready     = resetn & ((state == IDLE) | (state == ABSORB));
  assign accept        = msg_valid & msg_ready;
  assign perm_enable   = (state == PERM_START);
  assign digest_valid  = (state == SQUEEZE);
  assign busy          = (state != IDLE);
  assign perm_state_in = s;
  assign digest_data   = s[rd_base +: 32];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      s           <= '0;
      cnt         <= '0;
      fin         <= 1'b0;
      pad_pending <= 1'b0;
    end else begin
      case (state)
        IDLE, ABSORB: begin
          if (accept) begin
            s[wr_base +: 32] <= s[wr_base +: 32] ^ msg_data;
            if (msg_last) begin
              fin   <= 1'b1;
              cnt   <= '0;
              state <= PERM_START;
              // A full final block has no room for padding; it goes into the next block.
              if (widx != LAST) s[pad_base +: 32] <= s[pad_base +: 32] ^ 32'h0000_0001;
              else              pad_pending       <= 1'b1;
            end else if (widx == LAST) begin
              cnt   <= '0;
              state <= PERM_START;
            end else begin
              cnt   <= widx_nxt;
              state <= ABSORB;
            end
          end
        end
        PERM_START: state <= PERM_WAIT;
        PERM_WAIT: begin
          if (perm_done) begin
            cnt <= '0;
            if (pad_pending) begin
              s           <= perm_state_out ^ {32'h0000_0001, 352'h0};
              pad_pending <= 1'b0;
              state       <= PERM_START;
            end else begin
              s     <= perm_state_out;
              state <= fin ? SQUEEZE : ABSORB;
            end
          end
        end
        SQUEEZE: begin
          if (digest_ready) begin
            if (cnt == LAST) begin
              s     <= '0;
              cnt   <= '0;
              fin   <= 1'b0;
              state <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xoodoo_sponge_ctrl.sv
// Directed bench for xoodoo_sponge_ctrl; stands in for the permutation core with a word-rotate-and-XOR function.
module tb_xoodoo_sponge_ctrl;

  localparam int R = 4;
  localparam logic [31:0] K = 32'h9E37_79B9;

  logic         clk;
  logic         resetn;
  logic [31:0]  msg_data;
  logic         msg_valid;
  logic         msg_last;
  logic         msg_ready;
  logic         perm_enable;
  logic [0:383] perm_state_in;
  logic [0:383] perm_state_out;
  logic         perm_done;
  logic [31:0]  digest_data;
  logic         digest_valid;
  logic         digest_ready;
  logic         busy;

  xoodoo_sponge_ctrl #(.RATE_WORDS(R)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .msg_data       (msg_data),
    .msg_valid      (msg_valid),
    .msg_last       (msg_last),
    .msg_ready      (msg_ready),
    .perm_enable    (perm_enable),
    .perm_state_in  (perm_state_in),
    .perm_state_out (perm_state_out),
    .perm_done      (perm_done),
    .digest_data    (digest_data),
    .digest_valid   (digest_valid),
    .digest_ready   (digest_ready),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt = 0;
  int err_cnt = 0;

  int           pend;
  int           perm_delay;
  logic [0:383] pend_in;
  int           perm_pulses;
  int           pe_hi;
  logic         pe_prev;
  int           dv_hi;
  logic [0:383] perm_in_log [8];

  logic [31:0] msg   [16];
  logic [31:0] exp_d [4];

  task automatic chk(input string tag, input logic [383:0] got, input logic [383:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [0:383] fake_perm(input logic [0:383] x);
    return {x[32:383], x[0:31]} ^ {12{K}};
  endfunction

  // Textbook sponge: append 0x01, zero-fill to whole blocks, absorb each block then permute.
  function automatic void ref_digest(input logic [31:0] m [16], input int n, output logic [31:0] d [4]);
    logic [0:383] st;
    logic [31:0]  p [16];
    int           nblk;
    st = '0;
    for (int i = 0; i < 16; i++) p[i] = (i < n) ? m[i] : ((i == n) ? 32'h1 : 32'h0);
    nblk = (n + R) / R;
    for (int b = 0; b < nblk; b++) begin
      for (int j = 0; j < R; j++) st[32*j +: 32] = st[32*j +: 32] ^ p[b*R + j];
      st = fake_perm(st);
    end
    for (int j = 0; j < 4; j++) d[j] = st[32*j +: 32];
  endfunction

  // One clock; also plays the permutation core and tallies pulse activity.
  task automatic tick();
    @(posedge clk);
    #1;
    perm_done = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        perm_state_out = fake_perm(pend_in);
        perm_done      = 1'b1;
      end
    end
    if (perm_enable) begin
      pe_hi++;
      if (!pe_prev) begin
        if (perm_pulses < 8) perm_in_log[perm_pulses] = perm_state_in;
        perm_pulses++;
        pend    = perm_delay;
        pend_in = perm_state_in;
      end
    end
    pe_prev = perm_enable;
    if (digest_valid) dv_hi++;
  endtask

  task automatic clear_log();
    perm_pulses = 0;
    pe_hi       = 0;
    dv_hi       = 0;
  endtask

  task automatic send_msg(input logic [31:0] w [16], input int n);
    int guard;
    for (int i = 0; i < n; i++) begin
      msg_data  = w[i];
      msg_valid = 1'b1;
      msg_last  = (i == n - 1);
      guard     = 0;
      while (!msg_ready && guard < 200) begin
        tick();
        guard++;
      end
      chk($sformatf("msg_ready_w%0d", i), msg_ready, 1);
      tick();
    end
    msg_valid = 1'b0;
    msg_last  = 1'b0;
  endtask

  task automatic get_digest(input string tag, input logic [31:0] exp [4], input int stall_idx, input int stall_len);
    int          idx;
    int          guard;
    int          stall;
    logic [31:0] held;
    idx   = 0;
    guard = 0;
    stall = stall_len;
    held  = '0;
    while (idx < 4 && guard < 300) begin
      if (digest_valid) begin
        if (idx == stall_idx && stall > 0) begin
          if (stall == stall_len) held = digest_data;
          else chk($sformatf("%s_hold", tag), digest_data, held);
          digest_ready = 1'b0;
          stall--;
        end else begin
          chk($sformatf("%s_w%0d", tag, idx), digest_data, exp[idx]);
          digest_ready = 1'b1;
          idx++;
        end
      end else begin
        digest_ready = 1'b0;
      end
      tick();
      guard++;
    end
    digest_ready = 1'b0;
    chk($sformatf("%s_count", tag), idx, 4);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_dv"}, digest_valid, 0);
    chk({tag, "_s0"}, perm_state_in, 384'h0);
  endtask

  initial begin
    int g;
    resetn         = 1'b0;
    msg_data       = '0;
    msg_valid      = 1'b0;
    msg_last       = 1'b0;
    digest_ready   = 1'b0;
    perm_done      = 1'b0;
    perm_state_out = '0;
    pend           = 0;
    perm_delay     = 2;
    pend_in        = '0;
    pe_prev        = 1'b0;
    for (int i = 0; i < 16; i++) msg[i] = '0;
    clear_log();

    // Reset held for two cycles
    tick();
    chk("rst_msg_ready", msg_ready, 0);
    chk("rst_busy", busy, 0);
    tick();
    resetn = 1'b1;
    #1;
    chk("rel_busy", busy, 0);
    chk("rel_msg_ready", msg_ready, 1);
    chk("rel_perm_en", perm_enable, 0);
    chk("rel_dv", digest_valid, 0);
    chk("rel_s", perm_state_in, 384'h0);

    // Single word with last: pad lands in word 1
    clear_log();
    msg[0] = 32'hA5A5_A5A5;
    send_msg(msg, 1);
    chk("sw_pe_lat", perm_enable, 1);
    chk("sw_perm_in", perm_state_in, {32'hA5A5_A5A5, 32'h0000_0001, 320'h0});
    g = 0;
    while (!perm_done && g < 50) begin
      tick();
      g++;
    end
    chk("sw_done_seen", perm_done, 1);
    tick();
    chk("sw_dv_lat", digest_valid, 1);
    exp_d = '{32'h9E37_79B8, 32'h9E37_79B9, 32'h9E37_79B9, 32'h9E37_79B9};
    get_digest("sw", exp_d, -1, 0);
    chk("sw_pe_cycles", pe_hi, 1);
    check_idle("sw_end");

    // Full final block: padding needs a second permutation; words during PERM_WAIT are refused
    clear_log();
    perm_delay = 3;
    msg[0] = 32'd1; msg[1] = 32'd2; msg[2] = 32'd3; msg[3] = 32'd4;
    send_msg(msg, 4);
    msg_data  = 32'hDEAD_BEEF;
    msg_valid = 1'b1;
    chk("pw_ready_start", msg_ready, 0);
    tick();
    chk("pw_ready_wait", msg_ready, 0);
    msg_valid = 1'b0;
    exp_d = '{32'd3, 32'd4, 32'd0, 32'd0};
    get_digest("fb", exp_d, -1, 0);
    chk("fb_pulses", perm_pulses, 2);
    chk("fb_pe_cycles", pe_hi, 2);
    chk("fb_perm_in0", perm_in_log[0], {32'd1, 32'd2, 32'd3, 32'd4, 256'h0});
    chk("fb_perm_in1", perm_in_log[1], fake_perm(perm_in_log[0]) ^ {32'h0000_0001, 352'h0});
    check_idle("fb_end");

    // Digest backpressure on word 2
    clear_log();
    perm_delay = 2;
    msg[0] = 32'h1111_1111; msg[1] = 32'h2222_2222;
    send_msg(msg, 2);
    ref_digest(msg, 2, exp_d);
    get_digest("bp", exp_d, 2, 5);
    check_idle("bp_end");

    // Reset while waiting on the permutation; the late perm_done must be ignored
    clear_log();
    perm_delay = 4;
    msg[0] = 32'hCAFE_F00D;
    send_msg(msg, 1);
    tick();
    chk("rm_loaded", perm_state_in[0:31], 32'hCAFE_F00D);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    pe_hi = 0;
    dv_hi = 0;
    for (int i = 0; i < 6; i++) tick();
    chk("rm_busy", busy, 0);
    chk("rm_s", perm_state_in, 384'h0);
    chk("rm_dv", dv_hi, 0);
    chk("rm_pe", pe_hi, 0);
    chk("rm_ready", msg_ready, 1);

    // Back-to-back five-word messages
    perm_delay = 2;
    clear_log();
    msg[0] = 32'h0000_0010; msg[1] = 32'h0000_0020; msg[2] = 32'h0000_0030;
    msg[3] = 32'h0000_0040; msg[4] = 32'h0000_0050;
    send_msg(msg, 5);
    ref_digest(msg, 5, exp_d);
    get_digest("b1", exp_d, -1, 0);
    chk("b1_pulses", perm_pulses, 2);
    check_idle("b1_end");
    clear_log();
    msg[0] = 32'h0123_4567; msg[1] = 32'h89AB_CDEF; msg[2] = 32'hFEDC_BA98;
    msg[3] = 32'h7654_3210; msg[4] = 32'h0F0F_F0F0;
    send_msg(msg, 5);
    ref_digest(msg, 5, exp_d);
    get_digest("b2", exp_d, -1, 0);
    chk("b2_pulses", perm_pulses, 2);
    chk("b2_perm_in0", perm_in_log[0], {32'h0123_4567, 32'h89AB_CDEF, 32'hFEDC_BA98, 32'h7654_3210, 256'h0});
    check_idle("b2_end");

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench did not complete");
  end

endmodule
